// File: rtl/song_selector_pkg.sv
// song_selector_pkg: shared constants and state encoding for the song selector
//   NUM_SONGS_DEFAULT  default number of songs in the song ROM
//   SONG_W             width of the song number bus
//   state_t            play/stop FSM states
package song_selector_pkg;
  localparam int NUM_SONGS_DEFAULT = 4;
  localparam int SONG_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, RESTART = 2'd2} state_t;
endpackage

// File: rtl/song_selector_button_debouncer.sv
// button_debouncer: synchronises a raw button, debounces it, emits a 1-cycle press pulse
//   clk, reset  clock and synchronous active-high reset
//   btn         raw asynchronous button
//   press       1-cycle pulse on a debounced rising edge
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic level, level_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], btn};
      level_q <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign press = level & ~level_q;
endmodule

// File: rtl/song_selector.sv
// song_selector: debounced next/prev/play control, song counter and play/stop FSM for the player
//   clk, reset                    clock and synchronous active-high reset
//   btn_next, btn_prev, btn_play  raw asynchronous buttons
//   selected_song                 current song number, 0..NUM_SONGS-1
//   player_reset                  active-high player reset, 1 whenever not playing
//   playing                       status LED, 1 in PLAYING or RESTART
module song_selector
  import song_selector_pkg::*;
#(
  parameter int NUM_SONGS       = NUM_SONGS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int RESTART_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_play,
  output logic [SONG_W-1:0] selected_song,
  output logic              player_reset,
  output logic              playing
);
  localparam int RW = $clog2(RESTART_CYCLES + 1);
  localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);
  logic p_next, p_prev, p_play, move;
  state_t state, state_n;
  logic [SONG_W-1:0] song_n;
  logic [RW-1:0] rcnt, rcnt_n;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .reset(reset), .btn(btn_next), .press(p_next));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (.clk(clk), .reset(reset), .btn(btn_prev), .press(p_prev));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (.clk(clk), .reset(reset), .btn(btn_play), .press(p_play));
  // play dominates; simultaneous next and prev cancel out
  always_comb begin
    move = (p_next ^ p_prev) & ~p_play;
    song_n = !move ? selected_song
           : p_next ? (selected_song == LAST ? '0 : selected_song + 1'b1)
           : (selected_song == '0 ? LAST : selected_song - 1'b1);
    state_n = state;
    rcnt_n = '0;
    case (state)
      IDLE:    state_n = p_play ? PLAYING : IDLE;
      PLAYING: state_n = p_play ? IDLE : move ? RESTART : PLAYING;
      RESTART: begin
        state_n = p_play ? IDLE : move ? RESTART : rcnt == RW'(RESTART_CYCLES - 1) ? PLAYING : RESTART;
        rcnt_n = (p_play | move) ? '0 : rcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs derive from the next state so song and player_reset switch on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      selected_song <= '0;
      rcnt <= '0;
      player_reset <= 1'b1;
      playing <= 1'b0;
    end else begin
      state <= state_n;
      selected_song <= song_n;
      rcnt <= rcnt_n;
      player_reset <= state_n != PLAYING;
      playing <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_song_selector.sv
// tb_song_selector: directed and randomized bench for song_selector against a timeline reference model
module tb_song_selector;
  localparam int D = 4, R = 2, N = 4, HMAX = 4096;
  logic clk = 1'b0, reset = 1'b1, btn_next = 1'b0, btn_prev = 1'b0, btn_play = 1'b0;
  logic [3:0] selected_song;
  logic player_reset, playing;
  always #5 clk = ~clk;

  song_selector #(.NUM_SONGS(N), .DEBOUNCE_CYCLES(D), .RESTART_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .btn_play(btn_play),
    .selected_song(selected_song), .player_reset(player_reset), .playing(playing)
  );

  int checks = 0, errors = 0;
  int k = 0, rk = 0, pr_cnt = 0;
  bit armed = 0;
  bit raw_h [3][HMAX];
  bit lvl [3], rose [3];
  int lastflip [3];
  int m_song = 0, m_resume = 0;
  bit m_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // value seen by the debounce counter at edge e: the raw sample two edges earlier, zero across reset
  function automatic bit synced(input int b, input int e);
    return (e - 2 <= rk) ? 1'b0 : raw_h[b][e-2];
  endfunction

  task automatic step();
    bit p [3];
    bit all;
    @(posedge clk);
    k++;
    if (k >= HMAX) begin
      $display("FAIL history_overflow got %0d expected %0d", k, HMAX - 1);
      $fatal(1);
    end
    raw_h[0][k] = btn_next;
    raw_h[1][k] = btn_prev;
    raw_h[2][k] = btn_play;
    p = rose;
    if (reset) begin
      rk = k;
      for (int b = 0; b < 3; b++) begin lvl[b] = 0; rose[b] = 0; lastflip[b] = k; end
      m_song = 0;
      m_run = 0;
      armed = 1;
    end else begin
      for (int b = 0; b < 3; b++) begin
        rose[b] = 0;
        if (k - D >= lastflip[b]) begin
          all = 1;
          for (int i = 0; i < D; i++) if (synced(b, k - i) == lvl[b]) all = 0;
          if (all) begin lvl[b] = !lvl[b]; lastflip[b] = k; rose[b] = lvl[b]; end
        end
      end
      if (p[2]) begin
        if (m_run) m_run = 0;
        else begin m_run = 1; m_resume = k; end
      end else if (p[0] ^ p[1]) begin
        m_song = (m_song + (p[0] ? 1 : N - 1)) % N;
        if (m_run) m_resume = k + R;
      end
    end
    @(negedge clk);
    if (player_reset === 1'b1) pr_cnt++;
    if (armed) begin
      check("song", selected_song, m_song);
      check("playing", playing, m_run);
      check("player_reset", player_reset, !m_run || k < m_resume);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_next = v;
      1: btn_prev = v;
      default: btn_play = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    run(D + 3);
    set_btn(b, 1'b0);
    run(2 * D + 6);
  endtask

  int exp_seq [5] = '{1, 2, 3, 0, 3};
  logic [3:0] saved;

  initial begin
    run(2);
    reset = 1'b0;
    check("rst_song", selected_song, 0);
    check("rst_player_reset", player_reset, 1);
    check("rst_playing", playing, 0);
    // held next: song advances exactly 7 edges after the rise
    btn_next = 1'b1;
    run(6);
    check("t1_before", selected_song, 0);
    run(1);
    check("t1_after", selected_song, 1);
    check("t1_player_reset", player_reset, 1);
    run(13);
    btn_next = 1'b0;
    run(2 * D + 6);
    // short glitch is ignored
    btn_next = 1'b1;
    run(3);
    btn_next = 1'b0;
    run(12);
    check("t2_glitch", selected_song, 1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(i < 4 ? 0 : 1);
      check("t2_seq", selected_song, exp_seq[i]);
    end
    press(2);
    check("t3_playing", playing, 1);
    check("t3_player_reset", player_reset, 0);
    pr_cnt = 0;
    press(0);
    check("t3_restart_len", pr_cnt, R);
    check("t3_song", selected_song, 0);
    saved = selected_song;
    btn_next = 1'b1;
    btn_prev = 1'b1;
    run(D + 3);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    run(2 * D + 6);
    check("t4_cancel", selected_song, saved);
    press(2);
    check("t4_stopped", playing, 0);
    btn_next = 1'b1;
    btn_play = 1'b1;
    run(D + 3);
    btn_next = 1'b0;
    btn_play = 1'b0;
    run(2 * D + 6);
    check("t4_play_wins", playing, 1);
    check("t4_song_kept", selected_song, saved);
    press(0);
    btn_play = 1'b1;
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    check("t5_song", selected_song, 0);
    check("t5_player_reset", player_reset, 1);
    check("t5_playing", playing, 0);
    run(1);
    check("t5_no_pulse", playing, 0);
    btn_play = 1'b0;
    run(2 * D + 6);
    press(2);
    press(2);
    check("t6_stop_playing", playing, 0);
    check("t6_stop_reset", player_reset, 1);
    press(2);
    btn_next = 1'b1;
    run(1);
    btn_play = 1'b1;
    run(D + 3);
    btn_next = 1'b0;
    btn_play = 1'b0;
    run(2 * D + 6);
    check("t6_restart_abort", playing, 0);
    check("t6_restart_reset", player_reset, 1);
    check("t6_song", selected_song, 1);
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(5) == 0) btn_next = ~btn_next;
      if ($urandom_range(5) == 0) btn_prev = ~btn_prev;
      if ($urandom_range(5) == 0) btn_play = ~btn_play;
      reset = $urandom_range(199) == 0;
      run(1);
    end
    reset = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_play = 1'b0;
    run(2 * D + 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
